bp_zynq_cfg_reporter: RTL
=========================

Name: bp_zynq_cfg_reporter

Overview:
- Responder that returns the synthesized BlackParrot configuration to the PS host.
- It is the read side of the configuration selection. Elaborated parameter values, such as paddr_width, cache geometry and TLB sizes, are packed into 32-bit words and driven in on cfg_words_i.
- The host reads them by random access, or requests a framed stream dump into the PL-to-PS FIFO.
- It sits beside the shell's CSR block, between the BP top parameters and the host AXI-lite path.

Parameters:
- num_words_p, 24, number of 32-bit configuration words (range 1..255).
- magic_p, 16'hB9C0, header magic placed in bits [31:16] of the stream header word.
- lg_num_words_lp, $clog2(num_words_p+1), derived width of the word index and counter.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous active-high reset.
- cfg_words_i  input  32*num_words_p  packed config table; word i = bits [32*i+31:32*i]; must be static (tied to constants).
- rd_v_i  input  1  random-access read request.
- rd_addr_i  input  8  word index for the read.
- rd_data_o  output  32  read data.
- rd_v_o  output  1  read data valid.
- start_i  input  1  one-cycle pulse that requests a stream dump.
- stream_data_o  output  32  stream word.
- stream_v_o  output  1  stream word valid.
- stream_ready_i  input  1  stream consumer ready.
- busy_o  output  1  stream dump in progress.
- done_o  output  1  one-cycle pulse after the checksum word transfers.

Behaviour:
- Reset:
  - rd_v_o=0, rd_data_o=0.
  - stream_v_o=0, stream_data_o=0.
  - busy_o=0, done_o=0.
  - State=IDLE, counter=0, checksum=0.
  - A reset mid-dump aborts immediately; no further stream words are produced.
- Random access:
  - rd_v_i sampled high -> next cycle rd_v_o=1 and rd_data_o=word[rd_addr_i]; latency 1; one request per cycle, no backpressure.
  - rd_addr_i >= num_words_p -> rd_data_o=32'hDEAD_BEEF, rd_v_o=1.
  - rd_v_o deasserts the cycle after rd_v_i is sampled low.
  - Random access is independent of the stream FSM and legal while busy.
- Stream FSM states: IDLE, HDR, BODY, SUM.
- IDLE:
  - start_i=1 -> HDR; busy_o=1 from the next cycle.
  - Checksum and counter are cleared on that transition.
- HDR:
  - stream_v_o=1; stream_data_o={magic_p, 16'(num_words_p)}.
  - On valid&ready -> BODY, counter=0.
- BODY:
  - stream_v_o=1; stream_data_o=word[counter].
  - On valid&ready: checksum ^= word[counter] and counter++.
  - When the transferred word has counter==num_words_p-1 -> SUM.
- SUM:
  - stream_v_o=1; stream_data_o=checksum, the XOR of all body words; the header is excluded.
  - On valid&ready -> IDLE; done_o=1 for exactly one cycle (the cycle after the transfer); busy_o=0 in that same cycle.
- Handshake rules:
  - stream_v_o never drops, and stream_data_o is held stable, until ready is seen (AXI-stream style).
  - stream_v_o does not depend combinationally on stream_ready_i.
  - stream_v_o, stream_data_o, busy_o and done_o are registered or decoded from state and counter only.
- Throughput: one word per cycle with ready held high. A full dump takes num_words_p+2 transfers.
- start_i while busy_o=1 (including the HDR/BODY/SUM cycles) is ignored; it is neither queued nor a restart.
- start_i in the same cycle done_o is asserted is accepted, because the FSM is already in IDLE.
- Counter width lg_num_words_lp; the counter never wraps because SUM is entered at num_words_p-1.

Test Plan:
- Reset, then hold all inputs low for 5 cycles -> all outputs 0, busy_o=0.
- num_words_p=24 with word i=32'h1000_0000+i; rd_v_i with rd_addr_i=5 -> next cycle rd_v_o=1, rd_data_o=32'h1000_0005. rd_addr_i=24 -> 32'hDEAD_BEEF.
- Same table, start_i pulse, stream_ready_i=1 -> 26 consecutive words:
  - 32'hB9C0_0018, then 32'h1000_0000..32'h1000_0017, then 32'h0000_0000 (24 copies of 32'h1000_0000 XOR to 0; index XOR 0..23 = 0).
  - done_o on the cycle after the last transfer.
- Table word i=i+1 (24 words): checksum = 1^2^…^24 = 32'h0000_0018. Toggle stream_ready_i 1,0,1,0 -> each word is held stable while ready=0, with no duplicates or drops.
- start_i pulsed again during BODY -> ignored; exactly 26 words are produced. start_i in the done_o cycle -> a second full dump follows.
- reset_i asserted during BODY at counter=10 -> the next cycle has stream_v_o=0 and busy_o=0. A subsequent start_i produces a fresh header and a correct checksum.

Source files
------------

// File: rtl/bp_zynq_cfg_reporter.sv
// bp_zynq_cfg_reporter
// Returns the elaborated BlackParrot configuration table to the PS host.
// There are two ways to read it:
//   - a one-cycle-latency random-access read port;
//   - a framed stream dump: a header word, every table word in order, then
//     an XOR checksum of the table words.
// The table on cfg_words_i is expected to be static (tied to constants).

module bp_zynq_cfg_reporter #(
    parameter int          num_words_p     = 24,
    parameter logic [15:0] magic_p         = 16'hB9C0,
    parameter int          lg_num_words_lp = $clog2(num_words_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [32*num_words_p-1:0] cfg_words_i,
    input  logic                      rd_v_i,
    input  logic [7:0]                rd_addr_i,
    output logic [31:0]               rd_data_o,
    output logic                      rd_v_o,
    input  logic                      start_i,
    output logic [31:0]               stream_data_o,
    output logic                      stream_v_o,
    input  logic                      stream_ready_i,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam logic [1:0] st_idle_lp = 2'd0;
    localparam logic [1:0] st_hdr_lp  = 2'd1;
    localparam logic [1:0] st_body_lp = 2'd2;
    localparam logic [1:0] st_sum_lp  = 2'd3;

    localparam logic [lg_num_words_lp-1:0] last_idx_lp = lg_num_words_lp'(num_words_p - 1);
    localparam logic [31:0] hdr_word_lp = {magic_p, 16'(num_words_p)};
    localparam logic [31:0] bad_addr_lp = 32'hDEAD_BEEF;

    logic [31:0]                words_s [num_words_p];
    logic [31:0]                rd_word_s;
    logic [31:0]                body_word_s;
    logic                       xfer_s;

    logic [1:0]                 state_q, state_d;
    logic [lg_num_words_lp-1:0] cnt_q,   cnt_d;
    logic [31:0]                sum_q,   sum_d;
    logic                       done_q,  done_d;
    logic                       rd_v_q;
    logic [31:0]                rd_data_q;

    // Fold one more body word into the running checksum.
    function automatic logic [31:0] sum_fold(input logic [31:0] acc, input logic [31:0] word);
        return acc ^ word;
    endfunction

    // Unpack the flat configuration bus into an array of words.
    for (genvar g = 0; g < num_words_p; g++) begin : g_unpack
        assign words_s[g] = cfg_words_i[32*g +: 32];
    end

    // Select the read-port word and the current body word. Out-of-range read addresses return a marker value.
    always_comb begin
        rd_word_s   = bad_addr_lp;
        body_word_s = 32'h0000_0000;
        for (int i = 0; i < num_words_p; i++) begin
            rd_word_s   = (rd_addr_i == 8'(i)) ? words_s[i] : rd_word_s;
            body_word_s = (cnt_q == lg_num_words_lp'(i)) ? words_s[i] : body_word_s;
        end
    end

    // The stream outputs are decoded from state, counter and checksum only, so valid never depends on ready.
    always_comb begin
        case (state_q)
            st_hdr_lp:  stream_data_o = hdr_word_lp;
            st_body_lp: stream_data_o = body_word_s;
            st_sum_lp:  stream_data_o = sum_q;
            default:    stream_data_o = 32'h0000_0000;
        endcase
    end

    assign stream_v_o = (state_q != st_idle_lp);
    assign busy_o     = (state_q != st_idle_lp);
    assign done_o     = done_q;
    assign rd_v_o     = rd_v_q;
    assign rd_data_o  = rd_data_q;
    assign xfer_s     = stream_v_o & stream_ready_i;

    // Stream FSM next state: the header, then every table word, then the checksum.
    // A start request is only honoured while idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
        case (state_q)
            st_idle_lp: begin
                if (start_i) begin
                    state_d = st_hdr_lp;
                    cnt_d   = '0;
                    sum_d   = 32'h0000_0000;
                end else begin
                    state_d = st_idle_lp;
                end
            end
            st_hdr_lp: begin
                if (xfer_s) begin
                    state_d = st_body_lp;
                    cnt_d   = '0;
                end else begin
                    state_d = st_hdr_lp;
                end
            end
            st_body_lp: begin
                if (xfer_s) begin
                    sum_d = sum_fold(sum_q, body_word_s);
                    cnt_d = cnt_q + lg_num_words_lp'(1);
                    if (cnt_q == last_idx_lp) begin
                        state_d = st_sum_lp;
                    end else begin
                        state_d = st_body_lp;
                    end
                end else begin
                    state_d = st_body_lp;
                end
            end
            st_sum_lp: begin
                if (xfer_s) begin
                    state_d = st_idle_lp;
                    done_d  = 1'b1;
                end else begin
                    state_d = st_sum_lp;
                end
            end
            default: begin
                state_d = st_idle_lp;
            end
        endcase
    end

    // Stream FSM registers. Reset aborts any dump in progress immediately.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= st_idle_lp;
            cnt_q   <= '0;
            sum_q   <= 32'h0000_0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    // Random-access read port: one-cycle latency, independent of the stream FSM.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_v_q    <= 1'b0;
            rd_data_q <= 32'h0000_0000;
        end else begin
            rd_v_q <= rd_v_i;
            if (rd_v_i) begin
                rd_data_q <= rd_word_s;
            end else begin
                rd_data_q <= rd_data_q;
            end
        end
    end

endmodule
